// File: rtl/l2_set_writeback_if.sv
// Memory write port of the L2 set write-back sequencer: one way or the
// eviction pointer per accepted beat, back-pressured by mem_ready.
interface l2_set_writeback_if #(
  parameter int WAYS       = 8,
  parameter int WAY_BITS   = $clog2(WAYS),
  parameter int SET_BITS   = 8,
  parameter int LINE_BITS  = 128,
  parameter int TAG_BITS   = 16,
  parameter int HPROT_BITS = 1,
  parameter int STATE_BITS = 3
);
  // Handshake: a beat transfers on every rising edge where (wr_en | wr_en_evict_way)
  // and mem_ready are both high; until then the request and its data stay stable.
  logic                  wr_en;
  logic [WAY_BITS-1:0]   wr_way;
  logic [SET_BITS-1:0]   wr_set;
  logic [LINE_BITS-1:0]  wr_data_line;
  logic [TAG_BITS-1:0]   wr_data_tag;
  logic [HPROT_BITS-1:0] wr_data_hprot;
  logic [STATE_BITS-1:0] wr_data_state;
  logic                  wr_en_evict_way;
  logic [WAY_BITS-1:0]   wr_data_evict_way;
  logic                  mem_ready;

  modport master (
    output wr_en, wr_way, wr_set, wr_data_line, wr_data_tag, wr_data_hprot,
           wr_data_state, wr_en_evict_way, wr_data_evict_way,
    input  mem_ready
  );

  modport slave (
    input  wr_en, wr_way, wr_set, wr_data_line, wr_data_tag, wr_data_hprot,
           wr_data_state, wr_en_evict_way, wr_data_evict_way,
    output mem_ready
  );
endinterface

// File: rtl/l2_set_writeback.sv
// Writes modified L2 set-buffer ways and the eviction pointer back to memory.
// Optional feature macro: L2_SET_WB_DIRTY_ONLY_EN (write only dirty ways).
module l2_set_writeback #(
  parameter int WAYS       = 8,
  parameter int WAY_BITS   = $clog2(WAYS),
  parameter int SET_BITS   = 8,
  parameter int LINE_BITS  = 128,
  parameter int TAG_BITS   = 16,
  parameter int HPROT_BITS = 1,
  parameter int STATE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_mem_en,
  input  logic                  i_look,
  input  logic                  i_wr_en_lines_buf,
  input  logic                  i_wr_en_tags_buf,
  input  logic                  i_wr_en_states_buf,
  input  logic                  i_wr_en_hprots_buf,
  input  logic [WAY_BITS-1:0]   i_way,
  input  logic                  i_evict_way_dirty,
  input  logic                  i_start,
  input  logic [SET_BITS-1:0]   i_set,
  input  logic [LINE_BITS-1:0]  i_lines_buf  [WAYS],
  input  logic [TAG_BITS-1:0]   i_tags_buf   [WAYS],
  input  logic [HPROT_BITS-1:0] i_hprots_buf [WAYS],
  input  logic [STATE_BITS-1:0] i_states_buf [WAYS],
  input  logic [WAY_BITS-1:0]   i_evict_way_buf,
  l2_set_writeback_if.master    mem,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_state,
  output logic [WAYS-1:0]       o_dirty_mask,
  output logic                  o_evict_dirty
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_EVICT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [WAYS-1:0]     r_mask, r_snap, w_mask_nxt, w_snap_sel, w_low_onehot, w_snap_rest;
  logic                r_ev_flag, r_ev_pend, w_ev_flag_nxt;
  logic [SET_BITS-1:0] r_set;
  logic [WAY_BITS-1:0] w_low_way;
  logic                w_wr_en, w_wr_ev, w_done, w_beat, w_ev_acc, w_mark, w_load;

  assign w_mark = i_wr_en_lines_buf | i_wr_en_tags_buf | i_wr_en_states_buf | i_wr_en_hprots_buf;
  assign w_load = i_rd_mem_en & i_look;

`ifdef L2_SET_WB_DIRTY_ONLY_EN
  assign w_snap_sel = r_mask;
`else
  assign w_snap_sel = '1;
`endif

  // Lowest pending snapshot bit selects the way currently being written.
  always_comb begin
    w_low_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_snap[i]) w_low_way = WAY_BITS'(i);
    end
  end

  assign w_low_onehot = WAYS'(1) << w_low_way;
  assign w_snap_rest  = r_snap & ~w_low_onehot;

  always_comb begin
    w_next   = r_state;
    w_wr_en  = 1'b0;
    w_wr_ev  = 1'b0;
    w_done   = 1'b0;
    w_beat   = 1'b0;
    w_ev_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_snap_sel != '0)  w_next = S_WRITE;
          else if (r_ev_flag)    w_next = S_EVICT;
          else                   w_next = S_DONE;
        end
      end
      S_WRITE: begin
        w_wr_en = 1'b1;
        if (mem.mem_ready) begin
          w_beat = 1'b1;
          if (w_snap_rest == '0) w_next = r_ev_pend ? S_EVICT : S_DONE;
        end
      end
      S_EVICT: begin
        w_wr_ev = 1'b1;
        if (mem.mem_ready) begin
          w_ev_acc = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Clears are applied before marks so a same-cycle re-mark survives.
  always_comb begin
    w_mask_nxt    = r_mask;
    w_ev_flag_nxt = r_ev_flag;
    if (w_load) begin
      w_mask_nxt    = '0;
      w_ev_flag_nxt = 1'b0;
    end
    if (w_beat)            w_mask_nxt    = w_mask_nxt & ~w_low_onehot;
    if (w_ev_acc)          w_ev_flag_nxt = 1'b0;
    if (w_mark)            w_mask_nxt    = w_mask_nxt | (WAYS'(1) << i_way);
    if (i_evict_way_dirty) w_ev_flag_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_ev_flag <= 1'b0;
      r_snap    <= '0;
      r_ev_pend <= 1'b0;
      r_set     <= '0;
    end else begin
      r_state   <= w_next;
      r_mask    <= w_mask_nxt;
      r_ev_flag <= w_ev_flag_nxt;
      if (r_state == S_IDLE && i_start) begin
        r_snap    <= w_snap_sel;
        r_ev_pend <= r_ev_flag;
        r_set     <= i_set;
      end else if (w_beat) begin
        r_snap <= w_snap_rest;
      end
    end
  end

  assign mem.wr_en             = w_wr_en;
  assign mem.wr_way            = w_wr_en ? w_low_way : '0;
  assign mem.wr_set            = r_set;
  assign mem.wr_data_line      = w_wr_en ? i_lines_buf[w_low_way]  : '0;
  assign mem.wr_data_tag       = w_wr_en ? i_tags_buf[w_low_way]   : '0;
  assign mem.wr_data_hprot     = w_wr_en ? i_hprots_buf[w_low_way] : '0;
  assign mem.wr_data_state     = w_wr_en ? i_states_buf[w_low_way] : '0;
  assign mem.wr_en_evict_way   = w_wr_ev;
  assign mem.wr_data_evict_way = w_wr_ev ? i_evict_way_buf : '0;

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = w_done;
  assign o_state       = r_state;
  assign o_dirty_mask  = r_mask;
  assign o_evict_dirty = r_ev_flag;
endmodule

// File: doc/l2_set_writeback.md
# l2_set_writeback

Write-back sequencer for the L2 set buffers. After the controller has loaded a set into the per-way line/tag/hprot/state buffers and modified them, this block writes the modified ways and the updated eviction pointer back into the L2 memory arrays, one way per accepted beat. It sits between the set buffers and the memory write port, alongside the buffer block, and tracks which ways were touched since the last set load.

## Interface
- WAYS, default 8 (`LLC_WAYS`): ways per set; power of two, 2..16.
- WAY_BITS, default $clog2(WAYS): width of way indices.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- rd_mem_en, look  in  1 each  set load strobe; rd_mem_en & look clears the dirty mask.
- wr_en_lines_buf, wr_en_tags_buf, wr_en_states_buf, wr_en_hprots_buf  in  1 each  buffer write strobes; any high marks way dirty.
- way  in  WAY_BITS  way targeted by the buffer write strobes.
- evict_way_dirty  in  1  eviction pointer changed; marks the pointer for write-back.
- start  in  1  begin write-back of the current set; honoured only in IDLE.
- set  in  llc_set_t  set index; captured at start.
- lines_buf, tags_buf, hprots_buf, states_buf  in  arrays [WAYS]  buffer contents; held stable by the controller while busy.
- evict_way_buf  in  WAY_BITS  eviction pointer.
- mem_ready  in  1  memory accepts a write this cycle.
- wr_en  out  1  way write request.
- wr_way  out  WAY_BITS  way being written.
- wr_set  out  llc_set_t  captured set index.
- wr_data_line, wr_data_tag, wr_data_hprot, wr_data_state  out  line_t/llc_tag_t/hprot_t/llc_state_t  buffer contents of wr_way.
- wr_en_evict_way  out  1  eviction-pointer write request; wr_data_evict_way  out  WAY_BITS  = evict_way_buf.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.

## Operation
- FSM states: IDLE, WRITE, EVICT, DONE. Reset: IDLE, dirty mask 0, evict flag 0, snapshot 0, way index 0, set 0; all outputs 0.
- Dirty tracking (every state): strobe high -> mask[way] <= 1; evict_way_dirty -> evict flag <= 1; load strobe clears mask and flag; load and mark same cycle: mark wins.
- IDLE, start=1: snapshot <= selected ways (see Configuration), evict pending <= evict flag, set captured. Next state: WRITE if snapshot nonzero; else EVICT if pending; else DONE.
- WRITE: wr_en=1, wr_way = lowest set snapshot bit. Beat accepted when wr_en & mem_ready: clear that snapshot bit and the mask bit (unless re-marked same cycle). After last bit: EVICT if pending, else DONE.
- EVICT: wr_en_evict_way=1 until mem_ready; on accept clear evict flag (unless re-set same cycle) -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- wr_data_* are combinational muxes of the buffers by wr_way; wr_en and wr_en_evict_way never high together.
- start outside IDLE ignored. Reset low in any state: IDLE at that edge, in-flight beat dropped.

## Timing
- start at edge N -> first wr_en in cycle N+1.
- With mem_ready=1 throughout: k dirty ways + pointer -> k+1 write cycles, done in cycle N+k+2.
- mem_ready low holds wr_en, wr_way and wr_data_* stable; no way skipped.
- Empty snapshot, no pointer: done in cycle N+1, no writes.

## Configuration
- L2_SET_WB_DIRTY_ONLY_EN defined: snapshot = dirty mask; only marked ways written.
- Undefined: snapshot = all ones; all WAYS ways written in order 0..WAYS-1 regardless of mask; mask still tracked and cleared per accepted beat.

## Test plan
- Dirty-only, load, mark ways 2 and 5, start, mem_ready=1 -> wr_way 2 then 5 on consecutive cycles, wr_set = captured set, done 3 cycles after start.
- Mark way 3 + evict_way_dirty, evict_way_buf=6, mem_ready low 2 cycles on first beat -> way 3 held 3 cycles, then wr_en_evict_way with data 6, then done.
- Dirty-only, nothing marked, start -> no wr_en, done next cycle; start during busy -> ignored.
- Macro undefined, start -> wr_way 0..7 in 8 consecutive cycles, done at cycle 9.
- Mark way 1 in the same cycle its beat is accepted -> mask[1] remains 1 after completion.
- Reset low during second beat -> next cycle busy=0, wr_en=0, mask 0; following start with no marks -> done only.
